// File: rtl/i2c_master_rw.sv
// I2C master with multi-byte write/read bursts, ACK checking and open-drain SDA.
// Runs on ref_clk only; a quarter-bit tick enable paces every bus change.
module i2c_master_rw #(
    parameter int unsigned QDIV      = 125,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned LEN_W     = 3
) (
    input  logic                   ref_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             addr,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MAX_BYTES-1:0] wdata,
    input  logic                   sda_i,
    output logic                   i2c_scl,
    output logic                   sda_drive_low,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   ready,
    output logic                   done,
    output logic                   nack_err,
    output logic [3:0]             o_state
);

    localparam int unsigned DIV_W = $clog2(QDIV);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StStart   = 4'd1,
        StAddr    = 4'd2,
        StAddrAck = 4'd3,
        StWdata   = 4'd4,
        StWack    = 4'd5,
        StRdata   = 4'd6,
        StRack    = 4'd7,
        StStop    = 4'd8,
        StDone    = 4'd9
    } state_e;

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q;
    logic [1:0]             phase_q;
    logic [2:0]             bit_q;
    logic [LEN_W-1:0]       byte_q;
    logic [LEN_W-1:0]       last_q;
    logic                   rw_q;
    logic [6:0]             addr_q;
    logic [8*MAX_BYTES-1:0] wbuf_q;
    logic [7:0]             shift_q;
    logic                   samp_q;
    logic [LEN_W-1:0]       nbytes;
    logic [7:0]             tx_byte;
    logic                   tx_bit;
    logic                   tick;
    logic                   accept;
    logic                   bit_end;

    assign tick    = (div_q == DIV_W'(QDIV - 1));
    assign accept  = ready && start;
    assign bit_end = tick && (phase_q == 2'd3);
    assign o_state = state_q;
    assign tx_byte = (state_q == StAddr) ? {addr_q, rw_q} : wbuf_q[8*byte_q +: 8];
    assign tx_bit  = tx_byte[3'd7 - bit_q];

    // Byte count after mapping 0 to 1 and clamping to MAX_BYTES.
    always_comb begin
        if (len == '0) begin
            nbytes = LEN_W'(1);
        end else if (len > LEN_W'(MAX_BYTES)) begin
            nbytes = LEN_W'(MAX_BYTES);
        end else begin
            nbytes = len;
        end
    end

    // State register.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: bus states advance only at the end of a bit (last quarter tick).
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StStart;
            StDone:    state_d = start ? StStart : StIdle;
            StStart:   if (bit_end) state_d = StAddr;
            StAddr:    if (bit_end && bit_q == 3'd7) state_d = StAddrAck;
            StAddrAck: if (bit_end) state_d = samp_q ? StStop : (rw_q ? StRdata : StWdata);
            StWdata:   if (bit_end && bit_q == 3'd7) state_d = StWack;
            StWack:    if (bit_end) state_d = (samp_q || byte_q == last_q) ? StStop : StWdata;
            StRdata:   if (bit_end && bit_q == 3'd7) state_d = StRack;
            StRack:    if (bit_end) state_d = (byte_q == last_q) ? StStop : StRdata;
            StStop:    if (bit_end) state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath: divider, phase/bit/byte counters, latched request, sampling and read storage.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            div_q    <= '0;
            phase_q  <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= '0;
            last_q   <= '0;
            rw_q     <= 1'b0;
            addr_q   <= 7'd0;
            wbuf_q   <= '0;
            shift_q  <= 8'd0;
            samp_q   <= 1'b0;
            rdata    <= '0;
            nack_err <= 1'b0;
        end else if (accept) begin
            div_q    <= '0;
            phase_q  <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= '0;
            last_q   <= nbytes - LEN_W'(1);
            rw_q     <= rw;
            addr_q   <= addr;
            wbuf_q   <= wdata;
            nack_err <= 1'b0;
        end else if (state_q != StIdle) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                phase_q <= phase_q + 2'd1;
                // SDA is sampled at the end of the second SCL-high quarter.
                if (phase_q == 2'd2) begin
                    samp_q <= sda_i;
                    if (state_q == StRdata) shift_q <= {shift_q[6:0], sda_i};
                end
                if (phase_q == 2'd3) begin
                    case (state_q)
                        StAddr, StWdata: bit_q <= bit_q + 3'd1;
                        StRdata: begin
                            bit_q <= bit_q + 3'd1;
                            if (bit_q == 3'd7) rdata[8*byte_q +: 8] <= shift_q;
                        end
                        StAddrAck: if (samp_q) nack_err <= 1'b1;
                        StWack: begin
                            if (samp_q) nack_err <= 1'b1;
                            else        byte_q   <= byte_q + LEN_W'(1);
                        end
                        StRack:  byte_q <= byte_q + LEN_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs: bus levels decoded from state and quarter phase.
    always_comb begin
        i2c_scl       = 1'b1;
        sda_drive_low = 1'b0;
        ready         = 1'b0;
        done          = 1'b0;
        case (state_q)
            StIdle: ready = 1'b1;
            StDone: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            StStart: sda_drive_low = phase_q[1];
            StStop: begin
                i2c_scl       = (phase_q != 2'd0);
                sda_drive_low = !phase_q[1];
            end
            default: begin
                // Data/ACK bits: SCL high in the middle two quarters.
                i2c_scl = phase_q[0] ^ phase_q[1];
                case (state_q)
                    StAddr, StWdata: sda_drive_low = !tx_bit;
                    StRack:          sda_drive_low = (byte_q != last_q);
                    default:         sda_drive_low = 1'b0;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_rw.sv
// Bench for i2c_master_rw: bit-time plan model, cycle compare and bus decoder.
module tb_i2c_master_rw;

    localparam int Q    = 4;
    localparam int MAXB = 4;
    localparam int LW   = 3;
    localparam int BT   = 4 * Q;

    logic          ref_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          rw = 1'b0;
    logic [6:0]    addr = 7'd0;
    logic [LW-1:0] len = '0;
    logic [31:0]   wdata = 32'd0;
    logic          sda_i;
    logic          i2c_scl, sda_drive_low, ready, done, nack_err;
    logic [31:0]   rdata;
    logic [3:0]    o_state;

    i2c_master_rw #(.QDIV(Q), .MAX_BYTES(MAXB), .LEN_W(LW)) dut (
        .ref_clk       (ref_clk),
        .reset_n       (reset_n),
        .start         (start),
        .rw            (rw),
        .addr          (addr),
        .len           (len),
        .wdata         (wdata),
        .sda_i         (sda_i),
        .i2c_scl       (i2c_scl),
        .sda_drive_low (sda_drive_low),
        .rdata         (rdata),
        .ready         (ready),
        .done          (done),
        .nack_err      (nack_err),
        .o_state       (o_state)
    );

    always #5 ref_clk = ~ref_clk;

    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    // Plan: one entry per bit-time. kind 0=START, 1=data/ack bit, 2=STOP.
    int          plan_kind [64];
    bit          plan_mlow [64];
    bit          plan_slow [64];
    int          nbits = 0;
    bit          active = 1'b0;
    bit          idle_chk = 1'b0;
    int          acc = 0;
    int          done_count = 0;
    logic [31:0] exp_rdata = 32'd0, nxt_rdata = 32'd0;
    logic        exp_nack = 1'b0, nxt_nack = 1'b0;
    int          lit_tot = 0;
    logic [7:0]  lit_bytes[$];
    bit          lit_acks[$];
    bit          lit_rd_en = 1'b0;
    logic [15:0] lit_rd = 16'd0;
    int          checks = 0;
    int          errors = 0;

    // Slave pulls SDA low during bit-times the plan assigns to it.
    logic slave_low;
    always_comb begin
        slave_low = 1'b0;
        if (active && cyc >= acc && (cyc - acc) < nbits * BT) slave_low = plan_slow[(cyc - acc) / BT];
    end
    assign sda_i = !(sda_drive_low || slave_low);

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, req);
        end
    endtask

    // Compare process plus bus decoder (SCL-rise bits, START/STOP conditions).
    bit mon_bits[$];
    int mon_starts = 0, mon_stops = 0;
    bit p_scl = 1'b1, p_sda = 1'b1;
    always @(negedge ref_clk) begin
        int k, b, q, di;
        bit es, el, line;
        logic [7:0] by;
        line = !(sda_drive_low || slave_low);
        if (active) begin
            k = cyc - acc;
            if (k == 0) begin
                mon_bits.delete();
                mon_starts = 0;
                mon_stops  = 0;
            end
            if (p_scl && i2c_scl && p_sda && !line) mon_starts++;
            if (!p_scl && i2c_scl) mon_bits.push_back(line);
            if (p_scl && i2c_scl && !p_sda && line) begin
                mon_stops++;
                if (mon_bits.size() > 0) void'(mon_bits.pop_back());
            end
            if (k < nbits * BT) begin
                b = k / BT;
                q = (k / Q) % 4;
                if (plan_kind[b] == 0) begin
                    es = 1'b1;
                    el = (q >= 2);
                end else if (plan_kind[b] == 1) begin
                    es = (q == 1 || q == 2);
                    el = plan_mlow[b];
                end else begin
                    es = (q != 0);
                    el = (q < 2);
                end
                chk1("scl", i2c_scl, es);
                chk1("sda_drive_low", sda_drive_low, el);
                chk1("ready_busy", ready, 1'b0);
                chk1("done_busy", done, 1'b0);
            end else if (k == nbits * BT) begin
                chk1("done_end", done, 1'b1);
                chk1("ready_end", ready, 1'b1);
                chk1("nack_err_end", nack_err, nxt_nack);
                chk32("rdata_end", rdata, nxt_rdata);
                chk1("scl_end", i2c_scl, 1'b1);
                chk1("sda_end", sda_drive_low, 1'b0);
                di = 0;
                for (int i = 0; i < nbits; i++) begin
                    if (plan_kind[i] == 1) begin
                        if (di < mon_bits.size())
                            chk1("bus_bit", mon_bits[di], !(plan_mlow[i] || plan_slow[i]));
                        di++;
                    end
                end
                chk_int("bus_bit_count", mon_bits.size(), di);
                chk_int("bus_starts", mon_starts, 1);
                chk_int("bus_stops", mon_stops, 1);
                if (lit_tot != 0) chk_int("model_length", nbits * BT, lit_tot);
                for (int i = 0; i < lit_bytes.size(); i++) begin
                    if (mon_bits.size() >= 9 * i + 9) begin
                        by = 8'd0;
                        for (int j = 0; j < 8; j++) by = {by[6:0], mon_bits[9*i+j]};
                        chk32("bus_byte", {24'd0, by}, {24'd0, lit_bytes[i]});
                        chk1("bus_ack", mon_bits[9*i+8], lit_acks[i]);
                    end else begin
                        chk_int("bus_byte_present", mon_bits.size(), 9 * i + 9);
                    end
                end
                if (lit_rd_en) chk32("rdata_lo16", {16'd0, rdata[15:0]}, {16'd0, lit_rd});
                done_count++;
            end
        end else if (idle_chk) begin
            chk1("idle_scl", i2c_scl, 1'b1);
            chk1("idle_sda", sda_drive_low, 1'b0);
            chk1("idle_ready", ready, 1'b1);
            chk1("idle_done", done, 1'b0);
            chk1("idle_nack_err", nack_err, exp_nack);
            chk32("idle_rdata", rdata, exp_rdata);
            chk32("idle_state", {28'd0, o_state}, 32'd0);
        end
        p_scl = i2c_scl;
        p_sda = line;
    end

    task automatic put_bit(input int kind, input bit ml, input bit sl);
        plan_kind[nbits] = kind;
        plan_mlow[nbits] = ml;
        plan_slow[nbits] = sl;
        nbits++;
    endtask

    // Expand a request into bit-times from the protocol rules.
    task automatic build(input bit r, input logic [6:0] a, input int n_in, input logic [31:0] wd,
                         input logic [31:0] rd, input bit anack);
        int n;
        logic [7:0] by;
        n = (n_in == 0) ? 1 : ((n_in > MAXB) ? MAXB : n_in);
        nbits = 0;
        put_bit(0, 1'b0, 1'b0);
        by = {a, r};
        for (int i = 7; i >= 0; i--) put_bit(1, !by[i], 1'b0);
        put_bit(1, 1'b0, !anack);
        nxt_nack  = anack;
        nxt_rdata = exp_rdata;
        if (!anack) begin
            for (int k = 0; k < n; k++) begin
                if (!r) begin
                    by = wd[8*k +: 8];
                    for (int i = 7; i >= 0; i--) put_bit(1, !by[i], 1'b0);
                    put_bit(1, 1'b0, 1'b1);
                end else begin
                    by = rd[8*k +: 8];
                    for (int i = 7; i >= 0; i--) put_bit(1, 1'b0, !by[i]);
                    put_bit(1, (k != n - 1), 1'b0);
                    nxt_rdata[8*k +: 8] = by;
                end
            end
        end
        put_bit(2, 1'b0, 1'b0);
    endtask

    task automatic launch(input bit r, input logic [6:0] a, input logic [LW-1:0] l,
                          input logic [31:0] wd);
        @(posedge ref_clk); #1;
        start = 1'b1; rw = r; addr = a; len = l; wdata = wd;
        @(posedge ref_clk); #1;
        start  = 1'b0;
        acc    = cyc;
        active = 1'b1;
    endtask

    task automatic run(input bit r, input logic [6:0] a, input logic [LW-1:0] l,
                       input logic [31:0] wd, input logic [31:0] rd, input bit anack,
                       input bit poke);
        int dc0;
        build(r, a, int'(l), wd, rd, anack);
        dc0 = done_count;
        launch(r, a, l, wd);
        for (int t = 0; t < nbits * BT + 20; t++) begin
            if (done_count != dc0) break;
            if (poke && t == 40) begin
                start = 1'b1; addr = ~a; rw = ~r; wdata = ~wd; len = 3'd1;
            end
            if (poke && t == 41) start = 1'b0;
            @(posedge ref_clk); #1;
        end
        if (done_count == dc0) begin
            $display("FAIL done_timeout cyc=%0d got=none want=done pulse", cyc);
            $fatal(1, "no done pulse");
        end
        active    = 1'b0;
        exp_rdata = nxt_rdata;
        exp_nack  = nxt_nack;
        lit_bytes.delete();
        lit_acks.delete();
        lit_tot   = 0;
        lit_rd_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        reset_n  = 1'b1;
        idle_chk = 1'b1;
        repeat (3) @(posedge ref_clk);

        // Single-byte write, ACKed.
        lit_tot = 320; lit_bytes = '{8'h34, 8'hA5}; lit_acks = '{1'b0, 1'b0};
        run(1'b0, 7'h1A, 3'd1, 32'h0000_00A5, 32'd0, 1'b0, 1'b0);

        // Three-byte write with an ignored start pulse mid-transaction.
        lit_tot = 608; lit_bytes = '{8'h34, 8'h11, 8'h22, 8'h33};
        lit_acks = '{1'b0, 1'b0, 1'b0, 1'b0};
        run(1'b0, 7'h1A, 3'd3, 32'h0033_2211, 32'd0, 1'b0, 1'b1);

        // Two-byte read: master ACKs byte 0, NACKs byte 1.
        lit_tot = 464; lit_bytes = '{8'h91, 8'hC3, 8'h5A}; lit_acks = '{1'b0, 1'b0, 1'b1};
        lit_rd_en = 1'b1; lit_rd = 16'h5AC3;
        run(1'b1, 7'h48, 3'd2, 32'd0, 32'h0000_5AC3, 1'b0, 1'b0);

        // Address NACK: STOP right after the address byte.
        lit_tot = 176; lit_bytes = '{8'h44}; lit_acks = '{1'b1};
        run(1'b0, 7'h22, 3'd2, 32'h0000_7788, 32'd0, 1'b1, 1'b0);

        // len=0 moves exactly one byte; nack_err clears on accept.
        lit_tot = 320; lit_bytes = '{8'hA0, 8'h3C}; lit_acks = '{1'b0, 1'b0};
        run(1'b0, 7'h50, 3'd0, 32'hFFFF_FF3C, 32'd0, 1'b0, 1'b0);

        // len=7 clamps to four bytes.
        lit_tot = 752; lit_bytes = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h44};
        lit_acks = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run(1'b1, 7'h10, 3'd7, 32'd0, 32'h4433_2211, 1'b0, 1'b0);

        // Single-byte read keeps the upper rdata bytes.
        lit_rd_en = 1'b1; lit_rd = 16'h2277;
        run(1'b1, 7'h10, 3'd1, 32'd0, 32'h0000_0077, 1'b0, 1'b0);

        // Reset during WDATA abandons the bus; a new transaction then completes.
        build(1'b0, 7'h1A, 2, 32'h0000_BEEF, 32'd0, 1'b0);
        launch(1'b0, 7'h1A, 3'd2, 32'h0000_BEEF);
        repeat (12 * BT) @(posedge ref_clk);
        #1;
        active   = 1'b0;
        idle_chk = 1'b0;
        reset_n  = 1'b0;
        @(posedge ref_clk); #1;
        reset_n   = 1'b1;
        exp_rdata = 32'd0;
        exp_nack  = 1'b0;
        idle_chk  = 1'b1;
        repeat (4) @(posedge ref_clk);

        lit_tot = 320; lit_bytes = '{8'h56, 8'h5A}; lit_acks = '{1'b0, 1'b0};
        run(1'b0, 7'h2B, 3'd1, 32'h0000_005A, 32'd0, 1'b0, 1'b0);

        repeat (4) @(posedge ref_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
